// File: rtl/sync_fifo_pkg.sv
// Shared defaults and threshold legality check for the programmable-threshold synchronous FIFO.
package sync_fifo_pkg;

    localparam int unsigned DefDsize = 8;
    localparam int unsigned DefAsize = 4;

    // Almost-full must be reachable and nonzero; almost-empty must sit below full.
    function automatic bit levels_legal(input int unsigned depth, input int unsigned af,
                                        input int unsigned ae);
        return (af >= 1) && (af <= depth) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: DEPTH x DSIZE array, synchronous write port, asynchronous read port.
module sync_fifo_ram #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);

    logic [DSIZE-1:0] mem [2**ASIZE];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with registered occupancy flags, programmable thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read behaviour.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DSIZE    = DefDsize,
    parameter int unsigned ASIZE    = DefAsize,
    parameter int unsigned AF_LEVEL = (2 ** ASIZE) - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    input  logic             err_clr,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned   DEPTH    = 2 ** ASIZE;
    localparam logic [ASIZE:0] DepthCnt = DEPTH[ASIZE:0];
    localparam logic [ASIZE:0] AfLvl    = AF_LEVEL[ASIZE:0];
    localparam logic [ASIZE:0] AeLvl    = AE_LEVEL[ASIZE:0];

    if (!levels_legal(DEPTH, AF_LEVEL, AE_LEVEL)) begin : gen_bad_levels
        $error("sync_fifo_prog: AF_LEVEL/AE_LEVEL out of range for DEPTH");
    end

    logic [ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic             wfull_q, wfull_d, rempty_q, rempty_d;
    logic             afull_q, afull_d, aempty_q, aempty_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             wr_acc, rd_acc;
    logic [DSIZE-1:0] head;

    sync_fifo_ram #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (wr_acc),
        .waddr_i(wptr_q[ASIZE-1:0]),
        .wdata_i(wdata),
        .raddr_i(rptr_q[ASIZE-1:0]),
        .rdata_o(head)
    );

    // Flags are registered, so acceptance uses the pre-edge view of full/empty.
    always_comb begin
        wr_acc  = winc && !wfull_q;
        rd_acc  = rinc && !rempty_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) wptr_d = wptr_q + 1'b1;
        if (rd_acc) rptr_d = rptr_q + 1'b1;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wfull_d  = (count_d == DepthCnt);
        rempty_d = (count_d == '0);
        afull_d  = (count_d >= AfLvl);
        aempty_d = (count_d <= AeLvl);
        // A fresh error wins over a simultaneous clear.
        ovf_d    = (ovf_q && !err_clr) || (winc && wfull_q);
        unf_d    = (unf_q && !err_clr) || (rinc && rempty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through; masked to zero while empty so stale memory never shows.
    assign rdata  = rempty_q ? '0 : head;
    assign rvalid = !rempty_q;
`else
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    always_comb begin
        rdata_d  = rd_acc ? head : rdata_q;
        rvalid_d = rd_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

    assign wfull        = wfull_q;
    assign rempty       = rempty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
